// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sccb_pkg
// Description : Shared SCCB write-master state type, constants and frame builder.
// Revision    : 1.0
// ============================================================================
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } sccb_state_t;

    localparam logic [7:0] SCCB_WRITE_ID        = 8'h42;
    localparam int         SCCB_CLK_DIV_DEFAULT = 63;
    localparam int         SCCB_BITS_PER_XFER   = 27;
    localparam int         SCCB_XFER_QUARTERS   = 113;

    // Each byte goes out MSB first followed by the don't-care bit driven high.
    function automatic logic [SCCB_BITS_PER_XFER-1:0] sccb_frame(
        input logic [7:0] id,
        input logic [7:0] addr,
        input logic [7:0] data
    );
        return {id, 1'b1, addr, 1'b1, data, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sccb_tick_gen
// Description : Quarter-bit tick divider, restartable so ticks align to accept.
// Revision    : 1.0
// ============================================================================
module sccb_tick_gen #(
    parameter int CLK_DIV = 63
) (
    input  logic clk_25M,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/sccb_master.sv
`default_nettype none
// ============================================================================
// Module      : sccb_master
// Description : SCCB 3-phase write master (ID, sub-address, data) with push-pull SDA.
// Revision    : 1.0
// ============================================================================
module sccb_master
    import sccb_pkg::*;
#(
    parameter int         CLK_DIV = SCCB_CLK_DIV_DEFAULT,
    parameter logic [7:0] DEV_ID  = SCCB_WRITE_ID
) (
    input  logic       clk_25M,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       scl,
    output logic       sda,
    output logic       busy,
    output logic       done
);

    sccb_state_t                   r_state;
    logic [4:0]                    r_slot;
    logic [1:0]                    r_qtr;
    logic [SCCB_BITS_PER_XFER-1:0] r_shift;
    logic                          w_accept;
    logic                          w_tick;

    assign w_accept = (r_state == ST_IDLE) && start;

    sccb_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_25M (clk_25M),
        .rst_n   (rst_n),
        .restart (w_accept),
        .tick    (w_tick)
    );

    // Outputs are set for the quarter being entered, so every scl/sda change lands on a tick.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_qtr   <= '0;
            r_shift <= '0;
            scl     <= 1'b1;
            sda     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= ST_START;
                        r_slot  <= '0;
                        r_qtr   <= '0;
                        r_shift <= sccb_frame(DEV_ID, reg_addr, reg_data);
                        busy    <= 1'b1;
                        scl     <= 1'b1;
                        sda     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_qtr == 2'd0) begin
                            r_qtr <= 2'd1;
                            sda   <= 1'b0;
                        end else begin
                            r_state <= ST_BIT;
                            r_qtr   <= 2'd0;
                            r_slot  <= '0;
                            scl     <= 1'b0;
                            sda     <= r_shift[SCCB_BITS_PER_XFER-1];
                        end
                    end
                end
                ST_BIT: begin
                    if (w_tick) begin
                        r_qtr <= r_qtr + 2'd1;
                        if (r_qtr == 2'd1) begin
                            scl <= 1'b1;
                        end
                        if (r_qtr == 2'd3) begin
                            scl <= 1'b0;
                            if (r_slot == 5'(SCCB_BITS_PER_XFER - 1)) begin
                                r_state <= ST_STOP;
                                sda     <= 1'b0;
                            end else begin
                                r_slot  <= r_slot + 5'd1;
                                r_shift <= {r_shift[SCCB_BITS_PER_XFER-2:0], 1'b0};
                                sda     <= r_shift[SCCB_BITS_PER_XFER-2];
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_qtr <= r_qtr + 2'd1;
                        if (r_qtr == 2'd0) begin
                            scl <= 1'b1;
                        end else if (r_qtr == 2'd1) begin
                            sda <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_qtr   <= 2'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sccb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_master
// Description : Self-checking bench for sccb_master with CLK_DIV=4.
// Revision    : 1.0
// ============================================================================
module tb_sccb_master;

    localparam int DIV     = 4;
    localparam int LAT     = 113 * DIV;
    localparam int N_RISES = 28;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       scl;
    logic       sda;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    sccb_master #(
        .CLK_DIV (DIV)
    ) dut (
        .clk_25M  (clk),
        .rst_n    (rst_n),
        .start    (start),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .scl      (scl),
        .sda      (sda),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: every SCL rise samples one frame bit, then the STOP rise samples sda=0.
    function automatic logic [N_RISES-1:0] exp_rises(input logic [7:0] a, input logic [7:0] d);
        logic [7:0]        bytes [3];
        bit                q [$];
        logic [N_RISES-1:0] v;
        bytes = '{8'h42, a, d};
        for (int b = 0; b < 3; b++) begin
            for (int i = 7; i >= 0; i--) q.push_back(bytes[b][i]);
            q.push_back(1'b1);
        end
        q.push_back(1'b0);
        v = '0;
        for (int i = 0; i < N_RISES; i++) v[N_RISES-1-i] = q[i];
        return v;
    endfunction

    int                 cyc = 0;
    int                 t_acc = 0;
    int                 n_acc = 0;
    int                 n_done = 0;
    int                 last_lat = 0;
    int                 last_done_cyc = 0;
    int                 acc_gap = 0;
    int                 last_nbits = 0;
    logic [N_RISES-1:0] last_bits = '0;
    bit                 cap [$];
    logic               p_scl = 1'b1;
    logic               p_sda = 1'b1;
    logic               p_busy = 1'b0;
    logic               p_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && !p_busy) begin
                t_acc   = cyc;
                acc_gap = cyc - last_done_cyc;
                n_acc++;
                cap.delete();
            end
            chk("busy_and_done", 32'(busy && done), 32'd0);
            if (!busy) chk("idle_lines_high", {30'd0, scl, sda}, 32'd3);
            if (busy && (scl !== p_scl || sda !== p_sda)) begin
                chk("change_on_tick", 32'((cyc - t_acc) % DIV), 32'd0);
                if (p_scl && scl && sda !== p_sda) begin
                    chk("sda_stable_scl_high",
                        32'((p_sda && !sda && cap.size() == 0) ||
                            (!p_sda && sda && cap.size() == N_RISES)), 32'd1);
                end
            end
            if (busy && scl && !p_scl) cap.push_back(sda);
            if (done && !p_done) begin
                n_done++;
                last_lat      = cyc - t_acc;
                last_done_cyc = cyc;
                last_nbits    = cap.size();
                last_bits     = '0;
                for (int i = 0; i < cap.size() && i < N_RISES; i++) last_bits[N_RISES-1-i] = cap[i];
            end
        end
        p_scl  = scl;
        p_sda  = sda;
        p_busy = busy;
        p_done = done;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_xfer(input logic [7:0] a, input logic [7:0] d);
        start    = 1'b1;
        reg_addr = a;
        reg_data = d;
        step();
        start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int base);
        int k = 0;
        while (n_done == base && k < 2 * LAT) begin
            step();
            k++;
        end
        chk("done_seen", 32'(n_done), 32'(base + 1));
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] a, input logic [7:0] d);
        chk({tag, "_bits"}, 32'(last_bits), 32'(exp_rises(a, d)));
        chk({tag, "_nrises"}, 32'(last_nbits), N_RISES);
        chk({tag, "_latency"}, 32'(last_lat), LAT);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        int         base;
        int         acc0;

        rst_n    = 1'b0;
        start    = 1'b0;
        reg_addr = 8'h00;
        reg_data = 8'h00;
        repeat (3) step();
        chk("reset_scl", 32'(scl), 32'd1);
        chk("reset_sda", 32'(sda), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // Fixed pattern with a known bit string.
        base = n_done;
        start_xfer(8'h12, 8'h80);
        wait_done(base);
        check_xfer("s1", 8'h12, 8'h80);
        chk("s1_literal", 32'(last_bits), 32'({8'b01000010, 1'b1, 8'b00010010, 1'b1, 8'b10000000, 1'b1, 1'b0}));
        repeat (2) step();
        chk("s1_done_cleared", 32'(done), 32'd0);

        // Random payloads; inputs overwritten mid-transfer must not leak into the frame.
        for (int it = 0; it < 4; it++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            base = n_done;
            start_xfer(a, d);
            repeat (9) step();
            reg_addr = 8'hFF;
            reg_data = 8'hFF;
            wait_done(base);
            check_xfer("s5", a, d);
            repeat (2) step();
        end

        // Extra start pulse while busy is dropped, not queued.
        a = 8'($urandom);
        d = 8'($urandom);
        base = n_done;
        acc0 = n_acc;
        start_xfer(a, d);
        repeat (99) step();
        start    = 1'b1;
        reg_addr = ~a;
        step();
        start = 1'b0;
        wait_done(base);
        check_xfer("s3", a, d);
        repeat (6) step();
        chk("s3_single_done", 32'(n_done), 32'(base + 1));
        chk("s3_single_accept", 32'(n_acc), 32'(acc0 + 1));
        chk("s3_idle_after", 32'(busy), 32'd0);

        // Start held high: back-to-back transfers one idle cycle apart.
        a = 8'($urandom);
        d = 8'($urandom);
        base = n_done;
        acc0 = n_acc;
        start    = 1'b1;
        reg_addr = a;
        reg_data = d;
        repeat (600) step();
        start = 1'b0;
        chk("s2_two_accepts", 32'(n_acc), 32'(acc0 + 2));
        chk("s2_gap", 32'(acc_gap), 32'd2);
        wait_done(base + 1);
        check_xfer("s2", a, d);

        // Asynchronous reset mid-transfer aborts without a done pulse.
        repeat (2) step();
        a = 8'($urandom);
        d = 8'($urandom);
        base = n_done;
        start_xfer(a, d);
        repeat (199) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s4_async_scl", 32'(scl), 32'd1);
        chk("s4_async_sda", 32'(sda), 32'd1);
        chk("s4_async_busy", 32'(busy), 32'd0);
        chk("s4_async_done", 32'(done), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("s4_no_done", 32'(n_done), 32'(base));
        a = 8'($urandom);
        d = 8'($urandom);
        start_xfer(a, d);
        wait_done(base);
        check_xfer("s4", a, d);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sccb_master.md
SCCB_MASTER -- requirements
Module: sccb_master

Interface
REQ-001 Parameter CLK_DIV, default 63, is the number of clk_25M cycles per SCCB quarter-bit. 63 gives about a 99.2 kHz SCL.
REQ-002 Parameter DEV_ID, default 8'h42, is the camera write ID sent as phase 1.
REQ-003 Port clk_25M, input, 1 bit: the single clock.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port start, input, 1 bit: request one 3-phase write.
REQ-006 Port reg_addr, input, 8 bits: register sub-address for phase 2.
REQ-007 Port reg_data, input, 8 bits: register data for phase 3.
REQ-008 Port scl, output, 1 bit: SCCB clock.
REQ-009 Port sda, output, 1 bit: SCCB data, push-pull.
REQ-010 Port busy, output, 1 bit: high while a transfer is in progress.
REQ-011 Port done, output, 1 bit: one-cycle pulse when a transfer completes.

Function
REQ-012 start SHALL be accepted only when the state is IDLE; start while busy=1 SHALL be ignored and not queued.
REQ-013 On the accept edge, reg_addr and reg_data SHALL be latched, and busy SHALL read 1 from the next cycle.
- Later input changes SHALL NOT affect the transfer in flight.
REQ-014 A quarter tick SHALL fire once every CLK_DIV cycles.
- The tick counter restarts at 0 on accept.
- All scl/sda changes SHALL occur only on quarter ticks.
REQ-015 States SHALL be IDLE, START, BIT, STOP, DONE.
REQ-016 IDLE SHALL hold scl=1, sda=1.
REQ-017 START SHALL last 2 quarters: (scl=1, sda=1), then (scl=1, sda=0).
REQ-018 BIT SHALL last 27 slots (3 bytes x 9 bits) of 4 quarters each: (scl=0, sda=bit), (scl=0, sda=bit), (scl=1, sda=bit), (scl=1, sda=bit).
REQ-019 Byte order SHALL be DEV_ID, reg_addr, reg_data, each MSB first.
REQ-020 The 9th slot of each byte (don't-care bit) SHALL drive sda=1.
REQ-021 STOP SHALL last 3 quarters: (scl=0, sda=0), (scl=1, sda=0), (scl=1, sda=1).
REQ-022 sda SHALL never change while scl=1, except for the START and STOP edges.
REQ-023 At the end of STOP, DONE SHALL be entered for exactly 1 cycle: done=1 and busy=0 in that same cycle, then IDLE.
REQ-024 The accept-to-done latency SHALL be exactly 113*CLK_DIV cycles (2+108+3 quarters).
REQ-025 start asserted during the DONE cycle SHALL be ignored; start in the cycle after DONE SHALL be accepted.
REQ-026 The slot counter SHALL be 5 bits (0..26) and the quarter counter 2 bits; the divider SHALL be sized by $clog2(CLK_DIV).

Reset
REQ-027 rst_n=0 SHALL immediately force the state to IDLE, scl=1, sda=1, busy=0, done=0, and clear all counters and latched data.
REQ-028 Reset asserted mid-transfer SHALL abort it with no done pulse.
- After reset release, the first start SHALL begin a full fresh transfer.

Structure
REQ-029 Package sccb_pkg SHALL hold the state enumeration, SCCB_WRITE_ID (8'h42), SCCB_CLK_DIV_DEFAULT (63), SCCB_BITS_PER_XFER (27) and SCCB_XFER_QUARTERS (113).
REQ-030 One sub-module, sccb_tick_gen, SHALL implement the quarter-tick divider with a restart input.
REQ-031 The instantiating configuration FSM on the 25 MHz domain (clk_25M/rst_n) SHALL drive start and consume busy/done; this block is its direct downstream stage.

Verification
REQ-032 Bench SHALL run with CLK_DIV=4.
- Scenario 1: start with reg_addr=8'h12, reg_data=8'h80 -> sampled bits on scl rising edges are 01000010 1 00010010 1 10000000 1, and done arrives 452 cycles after accept.
- Scenario 2: start held high for 600 cycles -> exactly two transfers, separated by one idle cycle after done.
- Scenario 3: extra start pulse at cycle 100 of a transfer -> ignored; single done; shifted data unchanged.
- Scenario 4: rst_n low at cycle 200 -> scl=1, sda=1, busy=0 asynchronously; no done; next start produces a correct full transfer.
- Scenario 5: reg_addr/reg_data changed to 8'hFF at cycle 10 -> transmitted bytes are still the latched values.
- Scenario 6: protocol checker over all runs -> no sda transition while scl=1 other than START (falling) and STOP (rising); busy and done never both 1.
